// File: rtl/fifo_uart_dumper.sv
// Read-side sequencer: pops words from the debug FIFO and streams them LSB byte
// first into the byte-wide UART transmitter using its start/done handshake.
module fifo_uart_dumper #(
  parameter int unsigned B     = 32,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] num_words_i,
  input  logic             fifo_empty_i,
  input  logic [B-1:0]     fifo_r_data_i,
  output logic             fifo_rd_o,
  output logic             tx_start_o,
  output logic [7:0]       tx_data_o,
  input  logic             tx_done_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] words_sent_o
);

  localparam int unsigned BYTES = B / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_SEND   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [B-1:0]     shift_q, shift_d, shift_nxt;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             drain_q, drain_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fifo_rd_c;

  // Next-state logic; the pop strobe stays combinational so it can never
  // coincide with an empty FIFO, and abort suppresses it to avoid losing a word.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    drain_d     = drain_q;
    words_d     = words_q;
    tx_data_d   = tx_data_q;
    fifo_rd_c   = 1'b0;
    shift_nxt   = shift_q >> 8;

    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d     = S_FETCH;
            remaining_d = num_words_i;
            drain_d     = (num_words_i == '0);
            words_d     = '0;
          end
        end
        S_FETCH: begin
          if (!fifo_empty_i) begin
            fifo_rd_c = 1'b1;
            shift_d   = fifo_r_data_i;
            idx_d     = '0;
            tx_data_d = fifo_r_data_i[7:0];
            state_d   = S_SEND;
          end else if (drain_q) begin
            state_d = S_FINISH;
          end
        end
        S_SEND: state_d = S_WAIT;
        S_WAIT: begin
          if (tx_done_i) begin
            if (idx_q < IDX_W'(BYTES - 1)) begin
              shift_d   = shift_nxt;
              idx_d     = idx_q + IDX_W'(1);
              tx_data_d = shift_nxt[7:0];
              state_d   = S_SEND;
            end else begin
              words_d     = words_q + CNT_W'(1);
              remaining_d = remaining_q - CNT_W'(1);
              state_d     = (!drain_q && remaining_q == CNT_W'(1)) ? S_FINISH : S_FETCH;
            end
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end

    tx_start_d = (state_d == S_SEND);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      remaining_q <= '0;
      drain_q     <= 1'b0;
      words_q     <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
      drain_q     <= drain_d;
      words_q     <= words_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign fifo_rd_o    = fifo_rd_c;
  assign tx_start_o   = tx_start_q;
  assign tx_data_o    = tx_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign words_sent_o = words_q;

endmodule
